dnd_roll_ctrl: RTL and testbench

Arbitrated roll sequencer that shares one lfsr dice roller among NREQ players. It grants one request at a time, round-robin. For the granted request it:
- selects the roller's feedback tap set (mod);
- waits for the roller output to settle;
- rejection-samples the roller's 0–9 output into die faces;
- sums COUNT dice and returns a tagged total.

It sits between the player-input logic and the lfsr roller, and drives the roller's mod input.

---
 rtl/dnd_pkg.sv | 33 +++
 rtl/dnd_roll_ctrl_rr_arbiter.sv | 29 ++
 rtl/dnd_roll_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_dnd_roll_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dnd_pkg.sv
// Shared types and constants for the dice roll sequencer: die codes, FSM states, widths.
package dnd_pkg;

    localparam int RESULT_W = 7;
    localparam int ID_W     = 3;

    localparam logic [2:0] D2  = 3'd0;
    localparam logic [2:0] D4  = 3'd1;
    localparam logic [2:0] D6  = 3'd2;
    localparam logic [2:0] D8  = 3'd3;
    localparam logic [2:0] D10 = 3'd4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Unused codes 5-7 fall through to a d10.
    function automatic logic [3:0] die_faces(input logic [2:0] code);
        logic [3:0] faces_v;
        case (code)
            D2:      faces_v = 4'd2;
            D4:      faces_v = 4'd4;
            D6:      faces_v = 4'd6;
            D8:      faces_v = 4'd8;
            default: faces_v = 4'd10;
        endcase
        return faces_v;
    endfunction

endpackage

// File: rtl/dnd_roll_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: lowest set request at or above ptr, wrapping.
module rr_arbiter
    import dnd_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [ID_W-1:0] gnt_idx,
    output logic            gnt_valid
);

    // Unrolled over every pointer value so all request selects are constant.
    always_comb begin
        gnt_idx   = {ID_W{1'b0}};
        gnt_valid = 1'b0;
        for (int p = 0; p < NREQ; p++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ((ptr == ID_W'(p)) && !gnt_valid && req[(p + i) % NREQ]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = ID_W'((p + i) % NREQ);
                end else begin
                    gnt_valid = gnt_valid;
                end
            end
        end
    end

endmodule

// File: rtl/dnd_roll_ctrl.sv
// Round-robin roll sequencer sharing one lfsr roller among NREQ players.
// Optional DROP_LOWEST_EN: subtract the lowest accepted face when count >= 2.
module dnd_roll_ctrl
    import dnd_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int SETTLE    = 2,
    parameter int MAX_RETRY = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [3*NREQ-1:0]   die_sel,
    input  logic [3*NREQ-1:0]   count,
    input  logic [3:0]          rand_in,
    output logic [2:0]          mod_out,
    output logic                busy,
    output logic [ID_W-1:0]     gnt_id,
    output logic                done,
    output logic [ID_W-1:0]     done_id,
    output logic [RESULT_W-1:0] result
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int SET_W   = $clog2(SETTLE + 1);

    state_t              state_r, state_s;
    logic [ID_W-1:0]     ptr_r, ptr_s, gnt_id_r, gnt_id_s, done_id_r, done_id_s;
    logic [2:0]          mod_r, mod_s, remain_r, remain_s;
    logic                busy_r, busy_s, done_r, done_s;
    logic [RESULT_W-1:0] result_r, result_s, acc_r, acc_s, sum_s, final_s;
    logic [3:0]          faces_r, faces_s, face_s, rand_adj_s;
    logic [RETRY_W-1:0]  retry_r, retry_s;
    logic [SET_W-1:0]    settle_r, settle_s;
    logic                in_range_s, accept_s, arb_valid_s;
    logic [ID_W-1:0]     arb_idx_s;
    logic [2:0]          sel_die_s, sel_cnt_s;
`ifdef DROP_LOWEST_EN
    logic [3:0]          min_r, min_s, min_new_s;
    logic                multi_r, multi_s;
`endif

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req       (req),
        .ptr       (ptr_r),
        .gnt_idx   (arb_idx_s),
        .gnt_valid (arb_valid_s)
    );

    // Pick the die code and count of the requester the arbiter is offering.
    always_comb begin
        sel_die_s = 3'd0;
        sel_cnt_s = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (arb_idx_s == ID_W'(i)) begin
                sel_die_s = die_sel[3*i +: 3];
                sel_cnt_s = count[3*i +: 3];
            end else begin
                sel_die_s = sel_die_s;
                sel_cnt_s = sel_cnt_s;
            end
        end
    end

    // Rejection sampling; codes above 9 wrap by 10 only when the retry budget is spent.
    always_comb begin
        in_range_s = (rand_in < faces_r);
        rand_adj_s = (rand_in > 4'd9) ? (rand_in - 4'd10) : rand_in;
        accept_s   = in_range_s || (retry_r == RETRY_W'(MAX_RETRY));
        face_s     = in_range_s ? (rand_in + 4'd1) : ((rand_adj_s % faces_r) + 4'd1);
        sum_s      = acc_r + RESULT_W'(face_s);
`ifdef DROP_LOWEST_EN
        min_new_s  = (face_s < min_r) ? face_s : min_r;
        final_s    = multi_r ? (sum_s - RESULT_W'(min_new_s)) : sum_s;
`else
        final_s    = sum_s;
`endif
    end

    // Next-state and next-output logic of the sequencer.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        gnt_id_s  = gnt_id_r;
        done_id_s = done_id_r;
        mod_s     = mod_r;
        busy_s    = busy_r;
        done_s    = 1'b0;
        result_s  = result_r;
        acc_s     = acc_r;
        faces_s   = faces_r;
        remain_s  = remain_r;
        retry_s   = retry_r;
        settle_s  = settle_r;
`ifdef DROP_LOWEST_EN
        min_s     = min_r;
        multi_s   = multi_r;
`endif
        case (state_r)
            IDLE: begin
                if (arb_valid_s) begin
                    state_s  = dnd_pkg::SETTLE;
                    gnt_id_s = arb_idx_s;
                    mod_s    = (arb_idx_s == ID_W'(7)) ? 3'd0 : arb_idx_s;
                    busy_s   = 1'b1;
                    faces_s  = die_faces(sel_die_s);
                    remain_s = (sel_cnt_s == 3'd0) ? 3'd1 : sel_cnt_s;
                    acc_s    = {RESULT_W{1'b0}};
                    retry_s  = {RETRY_W{1'b0}};
                    settle_s = {SET_W{1'b0}};
`ifdef DROP_LOWEST_EN
                    min_s    = 4'd15;
                    multi_s  = (sel_cnt_s > 3'd1);
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            dnd_pkg::SETTLE: begin
                if (settle_r == SET_W'(SETTLE - 1)) begin
                    state_s = SAMPLE;
                end else begin
                    settle_s = settle_r + SET_W'(1);
                end
            end
            SAMPLE: begin
                if (accept_s) begin
                    acc_s    = sum_s;
                    remain_s = remain_r - 3'd1;
                    retry_s  = {RETRY_W{1'b0}};
`ifdef DROP_LOWEST_EN
                    min_s    = min_new_s;
`endif
                    if (remain_r == 3'd1) begin
                        state_s   = DONE;
                        done_s    = 1'b1;
                        done_id_s = gnt_id_r;
                        result_s  = final_s;
                        busy_s    = 1'b0;
                    end else begin
                        state_s = SAMPLE;
                    end
                end else begin
                    retry_s = retry_r + RETRY_W'(1);
                end
            end
            DONE: begin
                state_s = IDLE;
                ptr_s   = (gnt_id_r == ID_W'(NREQ - 1)) ? {ID_W{1'b0}} : (gnt_id_r + ID_W'(1));
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            ptr_r     <= {ID_W{1'b0}};
            gnt_id_r  <= {ID_W{1'b0}};
            done_id_r <= {ID_W{1'b0}};
            mod_r     <= 3'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= {RESULT_W{1'b0}};
            acc_r     <= {RESULT_W{1'b0}};
            faces_r   <= 4'd2;
            remain_r  <= 3'd0;
            retry_r   <= {RETRY_W{1'b0}};
            settle_r  <= {SET_W{1'b0}};
`ifdef DROP_LOWEST_EN
            min_r     <= 4'd15;
            multi_r   <= 1'b0;
`endif
        end else begin
            state_r   <= state_s;
            ptr_r     <= ptr_s;
            gnt_id_r  <= gnt_id_s;
            done_id_r <= done_id_s;
            mod_r     <= mod_s;
            busy_r    <= busy_s;
            done_r    <= done_s;
            result_r  <= result_s;
            acc_r     <= acc_s;
            faces_r   <= faces_s;
            remain_r  <= remain_s;
            retry_r   <= retry_s;
            settle_r  <= settle_s;
`ifdef DROP_LOWEST_EN
            min_r     <= min_s;
            multi_r   <= multi_s;
`endif
        end
    end

    assign mod_out = mod_r;
    assign busy    = busy_r;
    assign gnt_id  = gnt_id_r;
    assign done    = done_r;
    assign done_id = done_id_r;
    assign result  = result_r;

endmodule

// File: tb/tb_dnd_roll_ctrl.sv
// Self-checking bench for dnd_roll_ctrl: vector table plus scoreboard of expected rolls.
module tb_dnd_roll_ctrl;

    localparam int SETTLE_C = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [11:0] die_sel;
    logic [11:0] count;
    logic [3:0]  rand_in;
    logic [2:0]  mod_out;
    logic        busy;
    logic [2:0]  gnt_id;
    logic        done;
    logic [2:0]  done_id;
    logic [6:0]  result;

    dnd_roll_ctrl #(.NREQ(4), .SETTLE(SETTLE_C), .MAX_RETRY(7)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .die_sel (die_sel),
        .count   (count),
        .rand_in (rand_in),
        .mod_out (mod_out),
        .busy    (busy),
        .gnt_id  (gnt_id),
        .done    (done),
        .done_id (done_id),
        .result  (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [2:0]  die;
        logic [2:0]  cnt;
        logic [31:0] rnd;
        int          nrnd;
        int          samples;
        int          id;
        int          res;
        int          res_drop;
        bit          drop;
    } vec_t;

    typedef struct {
        int id;
        int res;
        int samples;
    } exp_t;

    vec_t        vecs [9];
    exp_t        sb_q [$];
    int          checks   = 0;
    int          failures = 0;
    int          busy_cnt = 0;
    logic [31:0] seq;
    int          seq_n;
    bit          drop_mid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input int id, input int res, input int samples);
        exp_t e;
        e.id = id;
        e.res = res;
        e.samples = samples;
        return e;
    endfunction

    // Act as requesters and roller until every queued roll has completed.
    task automatic serve(input int budget);
        int   cyc;
        int   idx;
        exp_t e;
        cyc = 0;
        while (sb_q.size() > 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                e = sb_q.pop_front();
                check("done_id", 32'(done_id), e.id);
                check("result", 32'(result), e.res);
                check("latency", busy_cnt, SETTLE_C + e.samples);
                req = req & ~(4'b0001 << e.id);
            end
            if (busy) begin
                busy_cnt++;
                if (busy_cnt == 1 && sb_q.size() > 0) begin
                    check("gnt_id", 32'(gnt_id), sb_q[0].id);
                    check("mod_out", 32'(mod_out), sb_q[0].id % 7);
                    if (drop_mid) req = req & ~(4'b0001 << sb_q[0].id);
                end
            end else begin
                busy_cnt = 0;
            end
            idx = busy_cnt - 1 - SETTLE_C;
            if (idx < 0) idx = 0;
            if (idx >= seq_n) idx = seq_n - 1;
            rand_in = seq[4*idx +: 4];
        end
        if (sb_q.size() > 0) begin
            check("serve_timeout", sb_q.size(), 0);
            sb_q.delete();
        end
    endtask

    initial begin
        int  cyc;
        bit  done_seen;
        //            req      die   cnt   rnd (low nibble first)  n  smp id res drop_res drop
        vecs[0] = '{4'b0100, 3'd4, 3'd3, 32'h0000_0004,          1, 3, 2, 15, 10, 1'b0};
        vecs[1] = '{4'b0001, 3'd2, 3'd1, 32'h0000_0389,          3, 3, 0,  4,  4, 1'b0};
        vecs[2] = '{4'b0010, 3'd1, 3'd1, 32'h0000_0009,          1, 8, 1,  2,  2, 1'b0};
        vecs[3] = '{4'b1000, 3'd2, 3'd4, 32'h0000_2305,          4, 4, 3, 14, 13, 1'b0};
        vecs[4] = '{4'b0001, 3'd0, 3'd7, 32'h0101_0101,          7, 7, 0, 11, 10, 1'b0};
        vecs[5] = '{4'b0010, 3'd3, 3'd0, 32'h0000_0007,          1, 1, 1,  8,  8, 1'b1};
        vecs[6] = '{4'b0100, 3'd6, 3'd2, 32'h0000_0009,          2, 2, 2, 11, 10, 1'b0};
        vecs[7] = '{4'b1000, 3'd4, 3'd1, 32'h0000_000F,          1, 8, 3,  6,  6, 1'b0};
        vecs[8] = '{4'b0001, 3'd4, 3'd7, 32'h0000_0009,          1, 7, 0, 70, 60, 1'b0};

        reset = 1'b0;
        req = 4'b0;
        die_sel = 12'd0;
        count = 12'd0;
        rand_in = 4'd0;
        seq = 32'd0;
        seq_n = 1;
        drop_mid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_result", 32'(result), 0);
        check("rst_done_id", 32'(done_id), 0);
        check("rst_gnt_id", 32'(gnt_id), 0);
        check("rst_mod_out", 32'(mod_out), 0);
        reset = 1'b1;

        for (int v = 0; v < 9; v++) begin
            die_sel  = {4{vecs[v].die}};
            count    = {4{vecs[v].cnt}};
            seq      = vecs[v].rnd;
            seq_n    = vecs[v].nrnd;
            drop_mid = vecs[v].drop;
`ifdef DROP_LOWEST_EN
            sb_q.push_back(mk(vecs[v].id, vecs[v].res_drop, vecs[v].samples));
`else
            sb_q.push_back(mk(vecs[v].id, vecs[v].res, vecs[v].samples));
`endif
            req = vecs[v].req;
            serve(200);
            req = 4'b0;
            @(negedge clk);
        end
        drop_mid = 1'b0;

        // Reset while id 1 is rejecting samples on a d2.
        die_sel = {4{3'd0}};
        count = {4{3'd1}};
        seq = 32'h5;
        seq_n = 1;
        rand_in = 4'd5;
        req = 4'b0010;
        busy_cnt = 0;
        cyc = 0;
        while (busy_cnt < SETTLE_C + 2 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (busy) busy_cnt++;
            else busy_cnt = 0;
        end
        check("reached_sample", 32'(busy_cnt >= SETTLE_C + 2), 1);
        reset = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_result", 32'(result), 0);
        check("midrst_mod_out", 32'(mod_out), 0);
        check("midrst_done_id", 32'(done_id), 0);
        reset = 1'b1;
        req = 4'b0;
        busy_cnt = 0;
        done_seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done) done_seen = 1'b1;
        end
        check("no_done_after_reset", 32'(done_seen), 0);

        // All four at once from pointer 0, then ids 0 and 3 only.
        die_sel = {4{3'd4}};
        count = {4{3'd1}};
        seq = 32'h0;
        seq_n = 1;
        for (int i = 0; i < 4; i++) sb_q.push_back(mk(i, 1, 1));
        req = 4'b1111;
        serve(400);
        sb_q.push_back(mk(0, 1, 1));
        sb_q.push_back(mk(3, 1, 1));
        req = 4'b1001;
        serve(200);
        req = 4'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
